mesh_sequencer: RTL
===================

Name: mesh_sequencer

Overview:
- Job-level controller for the NxN FP32 systolic Mesh.
- Per job: clears the mesh accumulators, fetches the N operand steps (column k of A, row k of B) from an upstream source, and issues them to the mesh one step at a time with the inputs_valid timing the mesh requires.
- After the last step it reads every PE accumulator in raster order and streams the results out on a valid/ready port.
- Sits between the job/DMA logic and the Mesh instance.

Parameters:
- N, 3, mesh dimension.
- DATA_WIDTH, 32, FP32 word width.
- GAP_CYCLES, 5, idle cycles between steps after diagonal completion.
- DRAIN_CYCLES, 10, idle cycles after the last step before readout.
- TIMEOUT, 1024, watchdog limit in cycles for any single wait on the mesh.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- start_i  in  1  job start; sampled in IDLE only.
- busy_o  out  1  high from job accept until done.
- done_o  out  1  one-cycle pulse at job end.
- err_o  out  1  sticky watchdog error; cleared by the next accepted start_i.
- op_req_o  out  1  operand request.
- op_idx_o  out  $clog2(N)  step index k of the requested operands.
- op_valid_i  in  1  operands present; accepted when op_req_o && op_valid_i.
- a_col_i  in  N*DATA_WIDTH  A[i][k]; word i at bits [i*DW +: DW].
- b_row_i  in  N*DATA_WIDTH  B[k][j]; word j at bits [j*DW +: DW].
- mesh_rstn_o  out  1  mesh reset = rstn_i AND internal clear_n.
- north_o  out  N*DATA_WIDTH  to mesh north_i.
- west_o  out  N*DATA_WIDTH  to mesh west_i.
- inputs_valid_o  out  1  to mesh inputs_valid_i.
- select_acc_o  out  N*N  to mesh select_accumulator_i; bit r*N+c.
- passthrough_valid_i  in  N*N  from mesh; bit r*N+c.
- accumulator_valid_i  in  N*N  from mesh; bit r*N+c.
- acc_data_i  in  N*N*DATA_WIDTH  east-going data bus of PE[r][c], slot r*N+c.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result ready.
- res_data_o  out  DATA_WIDTH  C[r][c].
- res_row_o  out  $clog2(N)  row index r.
- res_col_o  out  $clog2(N)  column index c.

Behaviour:
- Reset values: all outputs 0 except mesh_rstn_o, which follows rstn_i. Reset is asynchronous; mid-job reset returns the block to IDLE with no done_o pulse.
- IDLE: busy_o=0. On start_i: clear err_o, set k=0, go to CLEAR. start_i while busy_o=1 is ignored.
- CLEAR: clear_n=0 for 2 cycles, then 1 for 2 settle cycles, then go to FETCH.
- FETCH: op_req_o=1, op_idx_o=k. On the handshake, register a_col_i into west_o and b_row_i into north_o, drop op_req_o, go to ARM. north_o/west_o stay stable until the next fetch.
- ARM: inputs_valid_o=0 for 1 cycle, then go to FIRE.
- FIRE: inputs_valid_o=1 for exactly 1 cycle, then go to WAIT_DIAG with d=0.
- WAIT_DIAG: wait for passthrough_valid_i[d*N+d]. When it is seen, d++. After d==N-1 is seen, go to GAP. Bits are checked strictly in the order d=0,1,..,N-1; a later diagonal asserting early does not count.
- GAP: GAP_CYCLES idle cycles. Then k++ and go to FETCH if k<N. Otherwise go to DRAIN.
- DRAIN: DRAIN_CYCLES idle cycles, then go to SEL with r=c=0.
- SEL: select_acc_o bit r*N+c = 1 (one-hot; all others 0). On accumulator_valid_i[r*N+c]: capture slot r*N+c of acc_data_i into the result register, deassert select next cycle, go to OUT.
- OUT: res_valid_o=1 with data/row/col held stable until res_ready_i. On the handshake, advance raster order (c++, wrap to 0 with r++).
  - After PE[N-1][N-1]: go to IDLE, pulse done_o, busy_o falls the same cycle.
  - Otherwise: go to SEL.
- Watchdog:
  - Counts cycles while in WAIT_DIAG or SEL; reset on each state entry or successful event.
  - On reaching TIMEOUT: set err_o, clear select_acc_o and inputs_valid_o, go to IDLE, pulse done_o.
  - OUT backpressure is never timed.
- Minimum result latency: SEL capture to res_valid_o = 1 cycle. res_ready_i may be held high; throughput is then limited by the mesh valid latency.

Test Plan:
- Identity: A=1..9 (0x3F800000..0x41100000 raster), B=I -> 9 results in raster order equal to A; err_o=0; one done_o pulse.
- Dense: A={3,2,1;6,5,4;9,8,7}, B={2,4,6;1,3,5;7,8,9} -> 0x41700000,0x41D00000,0x42140000,0x42340000,0x428E0000,0x42C20000,0x42960000,0x42E80000,0x431D0000.
- Backpressure: res_ready_i low 7 cycles on result 4 -> res_valid_o held, data/row=1/col=1 stable, no result lost or duplicated.
- Operand stall: op_valid_i delayed 20 cycles on k=1 -> inputs_valid_o stays 0, correct results.
- Watchdog: force passthrough_valid_i[4]=0 -> err_o=1 after 1024 cycles, done_o pulse; next start_i clears err_o and completes cleanly.
- Reset mid-step (rstn_i low during WAIT_DIAG) -> all outputs 0, IDLE. start_i while busy -> ignored, single done_o.

Source files
------------

// File: rtl/mesh_sequencer.sv
// mesh_sequencer: job-level controller for the NxN FP32 systolic mesh.
//
// A job clears the mesh accumulators, then for each step k fetches column k
// of A and row k of B, fires them into the mesh with a single inputs_valid
// pulse, and waits for the diagonal PEs to report pass-through in order.
// After the last step has drained, each PE accumulator is selected in raster
// order and streamed out on a valid/ready result port.
//
// Ports
//   clk_i, rstn_i           clock, async active-low reset
//   start_i                 job start (taken only when idle)
//   busy_o, done_o, err_o   job status; err_o is a sticky watchdog flag
//   op_req_o, op_idx_o      operand request for step k
//   op_valid_i, a_col_i,
//   b_row_i                 operand response (A[i][k], B[k][j])
//   mesh_rstn_o             mesh reset (global reset AND job clear)
//   north_o, west_o,
//   inputs_valid_o          operand issue to the mesh
//   select_acc_o            one-hot accumulator select, bit r*N+c
//   passthrough_valid_i,
//   accumulator_valid_i,
//   acc_data_i              mesh status and per-PE data buses
//   res_valid_o, res_ready_i,
//   res_data_o, res_row_o,
//   res_col_o               result stream C[r][c]
module mesh_sequencer #(
  parameter int N            = 3,
  parameter int DATA_WIDTH   = 32,
  parameter int GAP_CYCLES   = 5,
  parameter int DRAIN_CYCLES = 10,
  parameter int TIMEOUT      = 1024
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic                         op_req_o,
  output logic [$clog2(N)-1:0]         op_idx_o,
  input  logic                         op_valid_i,
  input  logic [N*DATA_WIDTH-1:0]      a_col_i,
  input  logic [N*DATA_WIDTH-1:0]      b_row_i,
  output logic                         mesh_rstn_o,
  output logic [N*DATA_WIDTH-1:0]      north_o,
  output logic [N*DATA_WIDTH-1:0]      west_o,
  output logic                         inputs_valid_o,
  output logic [N*N-1:0]               select_acc_o,
  input  logic [N*N-1:0]               passthrough_valid_i,
  input  logic [N*N-1:0]               accumulator_valid_i,
  input  logic [N*N*DATA_WIDTH-1:0]    acc_data_i,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic [DATA_WIDTH-1:0]        res_data_o,
  output logic [$clog2(N)-1:0]         res_row_o,
  output logic [$clog2(N)-1:0]         res_col_o
);

  localparam int IW = $clog2(N);
  localparam int NN = N * N;
  // one counter serves clear timing, gap, drain and the watchdog
  localparam int CW = $clog2(TIMEOUT + GAP_CYCLES + DRAIN_CYCLES + 4) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_ARM, S_FIRE,
    S_WAIT_DIAG, S_GAP, S_DRAIN, S_SEL, S_OUT
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   k, d, r, c;
  logic [NN-1:0]   diag_oh, sel_oh;
  logic            diag_hit, sel_hit, wd_expire, counting, evt;
  logic            k_last, d_last, last_pe, res_hs, clear_n;
  int              sel_idx;

  // ---------------------------------------------------------------- decode
  always_comb begin
    sel_idx  = int'(r) * N + int'(c);
    diag_oh  = NN'(1) << (int'(d) * (N + 1));
    sel_oh   = NN'(1) << sel_idx;
    diag_hit = |(passthrough_valid_i & diag_oh);
    sel_hit  = |(accumulator_valid_i & sel_oh);
    k_last   = (k == IW'(N - 1));
    d_last   = (d == IW'(N - 1));
    last_pe  = (r == IW'(N - 1)) && (c == IW'(N - 1));
    res_hs   = (state == S_OUT) && res_ready_i;
    // successful mesh event in a timed state restarts the watchdog
    evt      = ((state == S_WAIT_DIAG) && diag_hit) || ((state == S_SEL) && sel_hit);
    wd_expire = ((state == S_WAIT_DIAG) || (state == S_SEL)) && !evt &&
                (cnt == CW'(TIMEOUT - 1));
    counting = (state == S_CLEAR) || (state == S_GAP) || (state == S_DRAIN) ||
               (state == S_WAIT_DIAG) || (state == S_SEL);
  end

  // ------------------------------------------------------- state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= S_IDLE;
    else         state <= state_nx;
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:      if (start_i) state_nx = S_CLEAR;
      S_CLEAR:     if (cnt == CW'(3)) state_nx = S_FETCH;
      S_FETCH:     if (op_valid_i) state_nx = S_ARM;
      S_ARM:       state_nx = S_FIRE;
      S_FIRE:      state_nx = S_WAIT_DIAG;
      S_WAIT_DIAG: if (diag_hit && d_last) state_nx = S_GAP;
                   else if (wd_expire)     state_nx = S_IDLE;
      S_GAP:       if (cnt == CW'(GAP_CYCLES - 1)) state_nx = k_last ? S_DRAIN : S_FETCH;
      S_DRAIN:     if (cnt == CW'(DRAIN_CYCLES - 1)) state_nx = S_SEL;
      S_SEL:       if (sel_hit)        state_nx = S_OUT;
                   else if (wd_expire) state_nx = S_IDLE;
      S_OUT:       if (res_ready_i) state_nx = last_pe ? S_IDLE : S_SEL;
      default:     state_nx = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------- outputs
  always_comb begin
    busy_o         = (state != S_IDLE);
    op_req_o       = (state == S_FETCH);
    inputs_valid_o = (state == S_FIRE);
    select_acc_o   = (state == S_SEL) ? sel_oh : '0;
    res_valid_o    = (state == S_OUT);
    // first two clear cycles hold the mesh in reset, next two let it settle
    clear_n        = !((state == S_CLEAR) && (cnt < CW'(2)));
  end

  assign mesh_rstn_o = rstn_i & clear_n;
  assign op_idx_o    = k;

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt        <= '0;
      k          <= '0;
      d          <= '0;
      r          <= '0;
      c          <= '0;
      north_o    <= '0;
      west_o     <= '0;
      res_data_o <= '0;
      res_row_o  <= '0;
      res_col_o  <= '0;
      err_o      <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      if ((state_nx != state) || evt || !counting) cnt <= '0;
      else                                         cnt <= cnt + 1'b1;

      if ((state == S_IDLE) && start_i) begin
        k     <= '0;
        err_o <= 1'b0;
      end
      if ((state == S_GAP) && (cnt == CW'(GAP_CYCLES - 1)) && !k_last) k <= k + 1'b1;

      if (state == S_FIRE) d <= '0;
      else if ((state == S_WAIT_DIAG) && diag_hit && !d_last) d <= d + 1'b1;

      if ((state == S_FETCH) && op_valid_i) begin
        west_o  <= a_col_i;
        north_o <= b_row_i;
      end

      if ((state == S_DRAIN) && (state_nx == S_SEL)) begin
        r <= '0;
        c <= '0;
      end else if (res_hs) begin
        if (c == IW'(N - 1)) begin
          c <= '0;
          r <= r + 1'b1;
        end else begin
          c <= c + 1'b1;
        end
      end

      if ((state == S_SEL) && sel_hit) begin
        res_data_o <= acc_data_i[sel_idx*DATA_WIDTH +: DATA_WIDTH];
        res_row_o  <= r;
        res_col_o  <= c;
      end

      if (wd_expire) err_o <= 1'b1;
      // registered so the pulse lines up with busy_o falling
      done_o <= (res_hs && last_pe) || wd_expire;
    end
  end

endmodule
